// File: rtl/credit_tx_rr_if.sv
// Link bundle between a credit-based transmitter and its receiver.
// Latency: none (wires only); the transmitter registers everything it drives.
// Backpressure: the receiver paces the transmitter by returning one credit per freed slot on vc_credit_gnt.
//
// Signals: vc_target      one-hot per-VC flit valid (transmitter -> receiver)
//          packet         routeinfo.addr = {x,y}, payload.data (transmitter -> receiver)
//          vc_credit_gnt  per-VC credit return pulse (receiver -> transmitter)

`ifndef DEFAULT_VC_W
`define DEFAULT_VC_W 2
`endif
`ifndef DEFAULT_D_W
`define DEFAULT_D_W 32
`endif
`ifndef DEFAULT_X_W
`define DEFAULT_X_W 4
`endif
`ifndef DEFAULT_Y_W
`define DEFAULT_Y_W 4
`endif

interface noc_if #(
    parameter int VC_W = `DEFAULT_VC_W,
    parameter int D_W  = `DEFAULT_D_W,
    parameter int X_W  = `DEFAULT_X_W,
    parameter int Y_W  = `DEFAULT_Y_W
);
    typedef struct packed {
        logic [X_W+Y_W-1:0] addr;
    } routeinfo_t;

    typedef struct packed {
        logic [D_W-1:0] data;
    } payload_t;

    typedef struct packed {
        routeinfo_t routeinfo;
        payload_t   payload;
    } packet_t;

    logic [VC_W-1:0] vc_target;
    logic [VC_W-1:0] vc_credit_gnt;
    packet_t         packet;

    modport transmitter (
        output vc_target,
        output packet,
        input  vc_credit_gnt
    );

    modport receiver (
        input  vc_target,
        input  packet,
        output vc_credit_gnt
    );
endinterface

// File: rtl/credit_tx_rr.sv
// Credit-based multi-VC transmitter: round-robin picks one eligible VC per cycle and forwards its flit.
// Latency: 1 cycle from acceptance (i_v[k] & !o_b[k]) to vc_target/packet on the link.
// Backpressure: o_b[k] = !grant[k]; a VC is only granted while it holds at least one credit.
//
// Ports: clk, rst (async, active-high)
//        to_rx       noc_if.transmitter link (vc_target, packet out; vc_credit_gnt in)
//        i_v/i_x/i_y/i_d  per-VC flit valid, destination x/y, payload from the switch
//        o_b         per-VC backpressure
//        o_err       sticky credit-overflow error (return received with the counter already full)
//        o_stall     per-VC stall watchdog flag; only live when CREDIT_TX_WATCHDOG_EN is defined,
//                    otherwise tied to zero

`ifndef DEFAULT_VC_W
`define DEFAULT_VC_W 2
`endif
`ifndef DEFAULT_D_W
`define DEFAULT_D_W 32
`endif
`ifndef DEFAULT_X_W
`define DEFAULT_X_W 4
`endif
`ifndef DEFAULT_Y_W
`define DEFAULT_Y_W 4
`endif
`ifndef DEFAULT_VC_FIFO_DEPTH
`define DEFAULT_VC_FIFO_DEPTH 4
`endif

module credit_tx_rr #(
    parameter int VC_W        = `DEFAULT_VC_W,
    parameter int D_W         = `DEFAULT_D_W,
    parameter int X_W         = `DEFAULT_X_W,
    parameter int Y_W         = `DEFAULT_Y_W,
    parameter int CREDITS     = `DEFAULT_VC_FIFO_DEPTH,
    parameter int STALL_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    noc_if.transmitter                to_rx,
    input  logic [VC_W-1:0]           i_v,
    input  logic [VC_W-1:0][X_W-1:0]  i_x,
    input  logic [VC_W-1:0][Y_W-1:0]  i_y,
    input  logic [VC_W-1:0][D_W-1:0]  i_d,
    output logic [VC_W-1:0]           o_b,
    output logic                      o_err,
    output logic [VC_W-1:0]           o_stall
);

    // Counter must hold the value CREDITS itself, not just CREDITS-1.
    localparam int            CW       = $clog2(CREDITS + 1);
    localparam int            PW       = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] LAST_VC  = PW'(VC_W - 1);

    logic [CW-1:0]        credit [VC_W];
    logic [PW-1:0]        ptr;
    logic [VC_W-1:0]      elig;
    logic [VC_W-1:0]      grant;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [PW-1:0]        ptr_nxt;

    logic [VC_W-1:0]      vc_target_q;
    logic [D_W-1:0]       data_q;
    logic [X_W+Y_W-1:0]   addr_q;
    logic                 err_q;

    // Eligibility uses the registered credit only: a credit returned this
    // cycle cannot fund a grant until the next cycle, so a VC at zero can
    // never be granted.
    always_comb begin
        for (int k = 0; k < VC_W; k++) begin
            elig[k] = i_v[k] && (credit[k] != '0);
        end
    end

    // Round-robin search starting at ptr, wrapping modulo VC_W. Reset gates
    // the grant so o_b reads all ones and nothing is launched while rst is high.
    always_comb begin
        int           pos;
        logic [PW-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int off = 0; off < VC_W; off++) begin
            pos = int'(ptr) + off;
            if (pos >= VC_W) begin
                pos = pos - VC_W;
            end
            idx = PW'(pos);
            if (!gnt_any && !rst && elig[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = idx;
                grant[idx]   = 1'b1;
            end
        end
    end

    assign ptr_nxt = (gnt_idx == LAST_VC) ? '0 : gnt_idx + PW'(1);
    assign o_b     = ~grant;

    // Credit accounting. The decrement happens in the grant cycle so the flit
    // sitting in the output register is already paid for. A grant and a
    // return on the same VC cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < VC_W; k++) begin
                credit[k] <= CRED_MAX;
            end
            ptr   <= '0;
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < VC_W; k++) begin
                if (grant[k] && !to_rx.vc_credit_gnt[k]) begin
                    credit[k] <= credit[k] - CW'(1);
                end else if (!grant[k] && to_rx.vc_credit_gnt[k]) begin
                    // A return with nothing outstanding is a receiver bug:
                    // saturate and flag it rather than wrapping.
                    if (credit[k] == CRED_MAX) begin
                        err_q <= 1'b1;
                    end else begin
                        credit[k] <= credit[k] + CW'(1);
                    end
                end
            end
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // Output register. vc_target pulses for exactly the cycle after a grant;
    // data/addr keep the last launched flit when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc_target_q <= '0;
            data_q      <= '0;
            addr_q      <= '0;
        end else begin
            vc_target_q <= grant;
            if (gnt_any) begin
                data_q <= i_d[gnt_idx];
                addr_q <= {i_x[gnt_idx], i_y[gnt_idx]};
            end
        end
    end

    assign to_rx.vc_target              = vc_target_q;
    assign to_rx.packet.payload.data    = data_q;
    assign to_rx.packet.routeinfo.addr  = addr_q;
    assign o_err                        = err_q;

`ifdef CREDIT_TX_WATCHDOG_EN
    // Counts consecutive cycles a VC has a flit waiting with no credit. A
    // credit arriving this cycle ends the stall, so the flag drops on the
    // cycle right after the return.
    logic [15:0] stall_cnt [VC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < VC_W; k++) begin
                stall_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < VC_W; k++) begin
                if (i_v[k] && (credit[k] == '0) && !to_rx.vc_credit_gnt[k]) begin
                    if (stall_cnt[k] != 16'hFFFF) begin
                        stall_cnt[k] <= stall_cnt[k] + 16'd1;
                    end
                end else begin
                    stall_cnt[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < VC_W; k++) begin
            o_stall[k] = (stall_cnt[k] >= 16'(STALL_LIMIT));
        end
    end
`else
    assign o_stall = '0;
`endif

    // Structural invariants of the arbiter and credit logic.
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_no_grant_at_zero : assert property (@(posedge clk) disable iff (rst)
        gnt_any |-> (credit[gnt_idx] != '0));

endmodule

// File: tb/tb_credit_tx_rr.sv
module tb_credit_tx_rr;

    localparam int VC_W = 2;
    localparam int D_W  = 8;
    localparam int X_W  = 4;
    localparam int Y_W  = 4;
    localparam int CRED = 4;
    localparam int SLIM = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [VC_W-1:0]          i_v;
    logic [VC_W-1:0][X_W-1:0] i_x;
    logic [VC_W-1:0][Y_W-1:0] i_y;
    logic [VC_W-1:0][D_W-1:0] i_d;
    logic [VC_W-1:0]          o_b;
    logic                     o_err;
    logic [VC_W-1:0]          o_stall;

    noc_if #(.VC_W(VC_W), .D_W(D_W), .X_W(X_W), .Y_W(Y_W)) rx ();

    credit_tx_rr #(
        .VC_W(VC_W), .D_W(D_W), .X_W(X_W), .Y_W(Y_W),
        .CREDITS(CRED), .STALL_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst(rst), .to_rx(rx),
        .i_v(i_v), .i_x(i_x), .i_y(i_y), .i_d(i_d),
        .o_b(o_b), .o_err(o_err), .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: expected link state one cycle after the stimulus,
    // plus the backpressure observed during the stimulus cycle.
    typedef struct {
        logic [1:0] exp_ob;
        logic [1:0] act_ob;
        logic [1:0] exp_tgt;
        logic [7:0] exp_data;
        logic [7:0] exp_addr;
        logic       exp_err;
    } item_t;

    item_t sb [$];

    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int         mcred [2];
    logic       mptr;
    logic       merr;
    logic [7:0] mdata;
    logic [7:0] maddr;
    logic [1:0] mlast;

    task automatic model_reset();
        mcred[0] = CRED;
        mcred[1] = CRED;
        mptr  = 1'b0;
        merr  = 1'b0;
        mdata = '0;
        maddr = '0;
        mlast = '0;
    endtask

    // Drives one cycle of stimulus, predicts the result, then advances to
    // just after the next rising edge.
    task automatic cycle(input logic [1:0] v, input logic [1:0] rtn);
        item_t      it;
        logic [1:0] g;
        logic       c;
        logic       found;
        logic       gsel;
        @(negedge clk);
        i_v              = v;
        rx.vc_credit_gnt = rtn;
        for (int k = 0; k < VC_W; k++) begin
            i_x[k] = 4'($urandom);
            i_y[k] = 4'($urandom);
            i_d[k] = 8'($urandom);
        end
        #1;
        g     = '0;
        found = 1'b0;
        gsel  = 1'b0;
        for (int off = 0; off < 2; off++) begin
            c = mptr ^ 1'(off);
            if (!found && v[c] && mcred[c] != 0) begin
                found = 1'b1;
                gsel  = c;
            end
        end
        if (found) begin
            g[gsel] = 1'b1;
            mdata   = i_d[gsel];
            maddr   = {i_x[gsel], i_y[gsel]};
            mptr    = ~gsel;
        end
        for (int k = 0; k < 2; k++) begin
            if (g[k] && !rtn[k]) begin
                mcred[k] = mcred[k] - 1;
            end else if (!g[k] && rtn[k]) begin
                if (mcred[k] == CRED) merr = 1'b1;
                else mcred[k] = mcred[k] + 1;
            end
        end
        it.exp_ob   = ~g;
        it.act_ob   = o_b;
        it.exp_tgt  = g;
        it.exp_data = mdata;
        it.exp_addr = maddr;
        it.exp_err  = merr;
        mlast       = g;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_v = 2'b11;
        i_x = '0;
        i_y = '0;
        i_d = '0;
        rx.vc_credit_gnt = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({o_b, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err, o_stall} !== {2'b11, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_state: ob/tgt/data/addr/err/stall = %b/%b/%h/%h/%b/%b, want 11/00/00/00/0/00",
                     o_b, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err, o_stall);
        end
        model_reset();
        @(negedge clk);
        i_v = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_vc();
        item_t it;
        for (int i = 0; i < 6; i++) begin
            cycle(2'b01, 2'b00);
            it = sb.pop_front();
            n_chk++;
            if ({it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err} !== {it.exp_ob, it.exp_tgt, it.exp_data, it.exp_addr, it.exp_err}) begin
                n_fail++;
                $display("FAIL single_vc[%0d]: ob/tgt/data/addr/err = %b/%b/%h/%h/%b, want %b/%b/%h/%h/%b", i,
                         it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err,
                         it.exp_ob, it.exp_tgt, it.exp_data, it.exp_addr, it.exp_err);
            end
        end
        n_chk++;
        if (dut.credit[0] !== 3'd0 || o_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_vc_drained: credit0=%0d ob0=%b, want 0/1", dut.credit[0], o_b[0]);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 2'b01);
            it = sb.pop_front();
            n_chk++;
            if ({it.act_ob, rx.vc_target, o_err} !== {it.exp_ob, it.exp_tgt, it.exp_err}) begin
                n_fail++;
                $display("FAIL refill[%0d]: ob/tgt/err = %b/%b/%b, want %b/%b/%b", i,
                         it.act_ob, rx.vc_target, o_err, it.exp_ob, it.exp_tgt, it.exp_err);
            end
        end
    endtask

    task automatic test_alternate();
        item_t      it;
        logic [1:0] prev;
        prev  = '0;
        mlast = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11, mlast);
            it = sb.pop_front();
            n_chk++;
            if ({it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err} !== {it.exp_ob, it.exp_tgt, it.exp_data, it.exp_addr, it.exp_err}) begin
                n_fail++;
                $display("FAIL alternate[%0d]: ob/tgt/data/addr/err = %b/%b/%h/%h/%b, want %b/%b/%h/%h/%b", i,
                         it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err,
                         it.exp_ob, it.exp_tgt, it.exp_data, it.exp_addr, it.exp_err);
            end
            if (i > 0) begin
                n_chk++;
                if (rx.vc_target !== ~prev) begin
                    n_fail++;
                    $display("FAIL alternate_order[%0d]: tgt=%b after %b, want %b", i, rx.vc_target, prev, ~prev);
                end
            end
            prev = rx.vc_target;
        end
        cycle(2'b00, mlast);
        void'(sb.pop_front());
    endtask

    task automatic test_same_cycle();
        item_t it;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b01, (i == 3) ? 2'b01 : 2'b00);
            it = sb.pop_front();
            n_chk++;
            if ({it.act_ob, rx.vc_target, rx.packet.payload.data, o_err} !== {it.exp_ob, it.exp_tgt, it.exp_data, it.exp_err}) begin
                n_fail++;
                $display("FAIL same_cycle[%0d]: ob/tgt/data/err = %b/%b/%h/%b, want %b/%b/%h/%b", i,
                         it.act_ob, rx.vc_target, rx.packet.payload.data, o_err,
                         it.exp_ob, it.exp_tgt, it.exp_data, it.exp_err);
            end
        end
        n_chk++;
        if (dut.credit[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL same_cycle_credit: credit0=%0d, want 1", dut.credit[0]);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00, 2'b01);
            void'(sb.pop_front());
        end
        n_chk++;
        if (dut.credit[0] !== 3'd4) begin
            n_fail++;
            $display("FAIL same_cycle_refill: credit0=%0d, want 4", dut.credit[0]);
        end
    endtask

`ifdef CREDIT_TX_WATCHDOG_EN
    task automatic test_stall();
        item_t it;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b01, 2'b00);
            void'(sb.pop_front());
        end
        for (int i = 1; i <= 5; i++) begin
            cycle(2'b01, 2'b00);
            it = sb.pop_front();
            n_chk++;
            if ({o_stall[0], it.act_ob, rx.vc_target} !== {(i >= SLIM), it.exp_ob, it.exp_tgt}) begin
                n_fail++;
                $display("FAIL stall[%0d]: stall0/ob/tgt = %b/%b/%b, want %b/%b/%b", i,
                         o_stall[0], it.act_ob, rx.vc_target, (i >= SLIM), it.exp_ob, it.exp_tgt);
            end
        end
        cycle(2'b01, 2'b01);
        void'(sb.pop_front());
        n_chk++;
        if (o_stall[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_clear: stall0=%b, want 0", o_stall[0]);
        end
        cycle(2'b01, 2'b00);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 2'b01);
            void'(sb.pop_front());
        end
    endtask
`endif

    task automatic test_overflow();
        item_t it;
        for (int i = 0; i < 2; i++) begin
            cycle(2'b00, (i == 0) ? 2'b10 : 2'b00);
            it = sb.pop_front();
            n_chk++;
            if ({it.act_ob, rx.vc_target, o_err} !== {it.exp_ob, it.exp_tgt, it.exp_err}) begin
                n_fail++;
                $display("FAIL overflow[%0d]: ob/tgt/err = %b/%b/%b, want %b/%b/%b", i,
                         it.act_ob, rx.vc_target, o_err, it.exp_ob, it.exp_tgt, it.exp_err);
            end
        end
        n_chk++;
        if (dut.credit[1] !== 3'd4 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sat: credit1=%0d err=%b, want 4/1", dut.credit[1], o_err);
        end
    endtask

    task automatic test_reset_mid();
        item_t it;
        cycle(2'b10, 2'b00);
        it = sb.pop_front();
        n_chk++;
        if ({rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr} !== {it.exp_tgt, it.exp_data, it.exp_addr} || it.exp_tgt !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_pre: tgt/data/addr = %b/%h/%h, want 10/%h/%h",
                     rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr, it.exp_data, it.exp_addr);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({rx.vc_target, o_b, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err} !== {2'b00, 2'b11, 8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_async: tgt/ob/data/addr/err = %b/%b/%h/%h/%b, want 00/11/00/00/0",
                     rx.vc_target, o_b, rx.packet.payload.data, rx.packet.routeinfo.addr, o_err);
        end
        n_chk++;
        if (dut.credit[0] !== 3'd4 || dut.credit[1] !== 3'd4 || dut.ptr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: credit0=%0d credit1=%0d ptr=%0d, want 4/4/0",
                     dut.credit[0], dut.credit[1], dut.ptr);
        end
        model_reset();
        @(negedge clk);
        i_v = '0;
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        item_t it;
        cycle(2'b11, 2'b00);
        it = sb.pop_front();
        n_chk++;
        if ({it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr} !== {it.exp_ob, it.exp_tgt, it.exp_data, it.exp_addr} || it.exp_tgt !== 2'b01) begin
            n_fail++;
            $display("FAIL first_grant: ob/tgt/data/addr = %b/%b/%h/%h, want %b/01/%h/%h",
                     it.act_ob, rx.vc_target, rx.packet.payload.data, rx.packet.routeinfo.addr,
                     it.exp_ob, it.exp_data, it.exp_addr);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_vc();
        test_alternate();
        test_same_cycle();
`ifdef CREDIT_TX_WATCHDOG_EN
        test_stall();
`endif
        test_overflow();
        test_reset_mid();
        test_first_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
